// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: ALU result capture, BEQ/BNE resolution, redirect and squash.
// Optional branch/bubble counters are built when EX_MEM_STATS_EN is defined.
module ex_mem_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic [DATA_W-1:0]     branch_target,
    input  logic                  is_beq,
    input  logic                  is_bne,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_dest_reg,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
`ifdef EX_MEM_STATS_EN
    output logic [31:0]           taken_cnt,
    output logic [31:0]           bubble_cnt,
`endif
    output logic                  pc_redirect,
    output logic [DATA_W-1:0]     pc_target
);

    localparam logic [1:0] SQ_INIT = 2'(SQUASH_DEPTH);

    logic [1:0] squash_cnt;
    logic       eff_valid;
    logic       capture;
    logic       taken;

    // Slot is real only outside the wrong-path window; BEQ+BNE together is not a branch.
    assign eff_valid = in_valid && (squash_cnt == 2'd0);
    assign capture   = !flush && !stall;
    assign taken     = eff_valid &&
                       ((is_beq && !is_bne && alu_zero) ||
                        (is_bne && !is_beq && !alu_zero));

    // MEM slot registers: flush bubbles the controls, stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_dest_reg   <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
        end else if (!stall) begin
            out_valid      <= eff_valid;
            out_result     <= alu_result;
            out_store_data <= rt_data;
            out_dest_reg   <= dest_reg;
            out_reg_write  <= reg_write && eff_valid;
            out_mem_read   <= mem_read && eff_valid;
            out_mem_write  <= mem_write && eff_valid;
        end
    end

    // Redirect is a single-cycle pulse; the target persists until the next taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_redirect <= 1'b0;
            pc_target   <= '0;
        end else begin
            pc_redirect <= capture && taken;
            if (capture && taken) begin
                pc_target <= branch_target;
            end
        end
    end

    // Wrong-path window: counts down only on accepted valid slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_cnt <= 2'd0;
        end else if (capture) begin
            if (taken) begin
                squash_cnt <= SQ_INIT;
            end else if (in_valid && squash_cnt != 2'd0) begin
                squash_cnt <= squash_cnt - 2'd1;
            end
        end
    end

`ifdef EX_MEM_STATS_EN
    // Event counters for taken branches and bubbles written into MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (capture && taken) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
            if (flush || (!stall && !eff_valid)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: driver pushes predicted MEM state per edge,
// monitor pops and compares after each edge.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          rst, in_valid, stall, flush;
    logic [DW-1:0] alu_result, rt_data, branch_target;
    logic          alu_zero, is_beq, is_bne;
    logic [RW-1:0] dest_reg;
    logic          reg_write, mem_read, mem_write;
    logic          out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [DW-1:0] out_result, out_store_data, pc_target;
    logic [RW-1:0] out_dest_reg;
    logic          pc_redirect;
`ifdef EX_MEM_STATS_EN
    logic [31:0]   taken_cnt, bubble_cnt;
`endif

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .SQUASH_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_result(alu_result), .alu_zero(alu_zero), .rt_data(rt_data),
        .branch_target(branch_target), .is_beq(is_beq), .is_bne(is_bne),
        .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .out_valid(out_valid), .out_result(out_result),
        .out_store_data(out_store_data), .out_dest_reg(out_dest_reg),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write),
`ifdef EX_MEM_STATS_EN
        .taken_cnt(taken_cnt), .bubble_cnt(bubble_cnt),
`endif
        .pc_redirect(pc_redirect), .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] result;
        logic [DW-1:0] sdata;
        logic [RW-1:0] dest;
        logic          rw, mr, mw;
        logic          redir;
        logic [DW-1:0] target;
        logic [31:0]   ntaken;
        logic [31:0]   nbubble;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   wrong_path;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    // Reference: the MEM slot as the spec's rules describe it, one edge per call.
    task automatic go(input logic r, v, st, fl, beq, bne, z, rw, mr, mw,
                      input logic [31:0] res, rt, tgt, input logic [4:0] d);
        bit real_slot, br_ok;
        rst = r; in_valid = v; stall = st; flush = fl;
        is_beq = beq; is_bne = bne; alu_zero = z;
        reg_write = rw; mem_read = mr; mem_write = mw;
        alu_result = res; rt_data = rt; branch_target = tgt; dest_reg = d;
        if (r) begin
            m = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
            wrong_path = 0;
        end else begin
            m.redir = 1'b0;
            if (fl) begin
                m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
                m.nbubble++;
            end else if (!st) begin
                real_slot = v && (wrong_path == 0);
                if (v && wrong_path > 0) wrong_path--;
                m.valid = real_slot;
                m.result = res; m.sdata = rt; m.dest = d;
                m.rw = rw & real_slot; m.mr = mr & real_slot; m.mw = mw & real_slot;
                br_ok = (beq != bne) && (beq ? z : !z);
                if (real_slot && br_ok) begin
                    m.redir = 1'b1; m.target = tgt;
                    wrong_path = SD;
                    m.ntaken++;
                end
                if (!real_slot) m.nbubble++;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] res, input logic [4:0] d);
        go(0, 1, 0, 0, 0, 0, res == 0, 1, 0, 0, res, 32'h55, 0, d);
    endtask

    task automatic br(input logic beq, bne, z, input logic [31:0] tgt);
        go(0, 1, 0, 0, beq, bne, z, 0, 0, 0, z ? 32'h0 : 32'h1, 0, tgt, 5'd0);
    endtask

    // Monitor: one expected entry belongs to each edge that follows its push.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                @(negedge clk);
                chk("valid", 32'(out_valid), 32'(e.valid));
                chk("result", out_result, e.result);
                chk("store_data", out_store_data, e.sdata);
                chk("dest_reg", 32'(out_dest_reg), 32'(e.dest));
                chk("reg_write", 32'(out_reg_write), 32'(e.rw));
                chk("mem_read", 32'(out_mem_read), 32'(e.mr));
                chk("mem_write", 32'(out_mem_write), 32'(e.mw));
                chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
                chk("pc_target", pc_target, e.target);
`ifdef EX_MEM_STATS_EN
                chk("taken_cnt", taken_cnt, e.ntaken);
                chk("bubble_cnt", bubble_cnt, e.nbubble);
`endif
            end
        end
    end

    initial begin
        logic z;
        rst = 1; in_valid = 0; stall = 0; flush = 0;
        alu_result = 0; alu_zero = 0; rt_data = 0; branch_target = 0;
        is_beq = 0; is_bne = 0; dest_reg = 0;
        reg_write = 0; mem_read = 0; mem_write = 0;
        m = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        wrong_path = 0;
        @(posedge clk);
        #1;
        go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // plain ALU op
        add(32'h7, 5'd8);
        // reset during a taken BEQ, then two unsquashed ops
        add(32'h11, 5'd3);
        go(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0040_0100, 0);
        add(32'h21, 5'd4);
        add(32'h22, 5'd5);
        // BEQ taken then three ADDs
        br(1, 0, 1, 32'h0040_0020);
        add(32'h31, 5'd6);
        add(32'h32, 5'd7);
        add(32'h33, 5'd9);
        // BNE not taken, then taken
        br(0, 1, 1, 32'h0040_0040);
        add(32'h41, 5'd10);
        br(0, 1, 0, 32'h0040_0080);
        add(32'h42, 5'd11);
        add(32'h43, 5'd12);
        add(32'h44, 5'd13);
        // decode error: both set, never a branch
        br(1, 1, 1, 32'h0040_00c0);
        go(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h9, 0, 0, 5'd14);
        // stall right after a taken BEQ
        br(1, 0, 1, 32'h0040_0200);
        repeat (3) go(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 32'h51, 0, 0, 5'd15);
        add(32'h52, 5'd16);
        add(32'h53, 5'd17);
        add(32'h54, 5'd18);
        // flush with stall on a store
        go(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000, 32'hdead, 0, 5'd0);
        // two taken branches and one flush
        go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        br(1, 0, 1, 32'h0040_0300);
        add(32'h61, 5'd1);
        add(32'h62, 5'd2);
        br(0, 1, 0, 32'h0040_0400);
        add(32'h63, 5'd3);
        add(32'h64, 5'd4);
        go(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 32'h65, 0, 0, 5'd5);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            z = ($urandom_range(0, 1) == 1);
            go($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, z,
               1'($urandom), 1'($urandom), 1'($urandom),
               z ? 32'h0 : ($urandom | 32'h1), $urandom, $urandom,
               5'($urandom));
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the 5-stage MIPS core. It is the consumer side of the EX-stage ALU.
- Captures the ALU result and zero flag together with memory and write-back control, and resolves BEQ/BNE from the zero flag.
- Issues a one-cycle PC redirect and squashes the younger wrong-path instructions.
- Honours stall and flush requests from the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target
- REG_ADDR_W, 5, destination register index width
- SQUASH_DEPTH, 2, number of accepted younger slots squashed after a taken branch (1..3)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX slot holds a real instruction
- stall  in  1  hold all stage registers this cycle
- flush  in  1  replace the slot being captured with a bubble
- alu_result  in  DATA_W  ALU result for this instruction
- alu_zero  in  1  ALU zero flag (1 when alu_result == 0)
- rt_data  in  DATA_W  store data
- branch_target  in  DATA_W  computed branch target address
- is_beq  in  1  instruction is BEQ
- is_bne  in  1  instruction is BNE
- dest_reg  in  REG_ADDR_W  write-back register index
- reg_write  in  1  write-back enable
- mem_read  in  1  load
- mem_write  in  1  store
- out_valid  out  1  MEM slot valid
- out_result  out  DATA_W  registered ALU result
- out_store_data  out  DATA_W  registered rt_data
- out_dest_reg  out  REG_ADDR_W  registered dest_reg
- out_reg_write  out  1  qualified write-back enable
- out_mem_read  out  1  qualified load enable
- out_mem_write  out  1  qualified store enable
- pc_redirect  out  1  one-cycle pulse: fetch from pc_target
- pc_target  out  DATA_W  redirect address

Behaviour:
- Reset: rst sampled high on a clk edge clears every output and internal register to 0, and squash_cnt to 0. Reset overrides flush and stall; a branch in flight is dropped.
- Priority each edge: rst > flush > stall > normal capture.
- Qualified slot: eff_valid = in_valid && (squash_cnt == 0).
- Normal capture (no stall, no flush):
  - out_valid <= eff_valid.
  - Data fields (out_result, out_store_data, out_dest_reg) load unconditionally.
  - out_reg_write, out_mem_read and out_mem_write load their inputs ANDed with eff_valid, so a bubble never writes.
  - Latency is 1 cycle from EX inputs to outputs.
- Branch resolution is combinational on the inputs and registered at capture: taken = eff_valid && ((is_beq && alu_zero) || (is_bne && !alu_zero)).
  - is_beq and is_bne both high counts as a decode error; the slot is treated as not-a-branch.
  - On taken: pc_redirect <= 1, pc_target <= branch_target, squash_cnt <= SQUASH_DEPTH.
  - The branch itself is written into MEM normally; its write controls are already 0 from decode.
- pc_redirect is a single-cycle pulse.
  - It is cleared on the next edge regardless of stall, so a stalled stage never re-fires a redirect.
  - pc_target holds its value until the next taken branch.
- Squash counter: on each normal capture with in_valid=1 and squash_cnt>0, the slot becomes a bubble and squash_cnt decrements by 1. Stalled cycles and in_valid=0 cycles do not decrement it. Saturates at 0.
- Stall (flush=0): all out_* registers and squash_cnt hold. pc_redirect still clears to 0.
- Flush:
  - out_valid, out_reg_write, out_mem_read and out_mem_write go to 0; data fields hold.
  - No branch is resolved that cycle, so the slot's branch is lost.
  - squash_cnt holds.
  - Flush with stall behaves as flush.
- Back-to-back taken branches cannot occur: the second branch is inside the squash window and is squashed.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined: adds two outputs.
  - taken_cnt (out, 32): increments on each taken-branch capture.
  - bubble_cnt (out, 32): increments on each non-stalled edge that writes out_valid=0 (from in_valid=0, squash, or flush).
  - Both are cleared by rst and wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-operation: capture a valid ADD, then hold rst high for 1 cycle during a taken BEQ -> all outputs 0, pc_redirect stays 0, and the next two valid instructions pass unsquashed.
2. Plain ALU op: in_valid=1, alu_result=0x0000_0007, dest_reg=8, reg_write=1 -> next cycle out_valid=1, out_result=7, out_dest_reg=8, out_reg_write=1, pc_redirect=0.
3. BEQ taken: is_beq=1, alu_zero=1, branch_target=0x0040_0020, then 3 valid ADDs with reg_write=1 -> pc_redirect=1 for exactly 1 cycle, pc_target=0x0040_0020, the first 2 ADDs arrive with out_valid=0 and out_reg_write=0, the 3rd passes.
4. BNE not taken vs taken: is_bne=1, alu_zero=1 -> pc_redirect=0 and no squash. is_bne=1, alu_zero=0 -> redirect pulse and squash_cnt=2.
5. Stall/flush interplay:
   - Stall for 3 cycles right after a taken BEQ -> pc_redirect is high for 1 cycle only, outputs hold, and the squash window still covers the next 2 accepted valid slots.
   - Flush together with stall on a valid SW (mem_write=1) -> out_valid=0 and out_mem_write=0.
6. EX_MEM_STATS_EN: 2 taken branches plus 1 flush -> taken_cnt=2, bubble_cnt=5 (4 squashed slots + 1 flush).
